// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready request/response pair
// into AXI4-Lite reads and writes, with a bounded response timeout and a post-timeout drain.
module axi_lite_cfg_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [2:0]  PROT           = 3'b000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [3:0]        i_req_wstrb,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_error,
  output logic              o_rsp_timeout,
  output logic              o_m_cfg_in_m_awvalid_0,
  output logic [ADDR_W-1:0] o_m_cfg_in_m_awaddr_0,
  output logic [2:0]        o_m_cfg_in_m_awprot_0,
  output logic              o_m_cfg_in_m_wvalid_0,
  output logic [31:0]       o_m_cfg_in_m_wdata_0,
  output logic [3:0]        o_m_cfg_in_m_wstrb_0,
  output logic              o_m_cfg_in_m_bready_0,
  output logic              o_m_cfg_in_m_arvalid_0,
  output logic [ADDR_W-1:0] o_m_cfg_in_m_araddr_0,
  output logic [2:0]        o_m_cfg_in_m_arprot_0,
  output logic              o_m_cfg_in_m_rready_0,
  input  logic              i_m_cfg_out_m_awready_0,
  input  logic              i_m_cfg_out_m_wready_0,
  input  logic              i_m_cfg_out_m_arready_0,
  input  logic              i_m_cfg_out_m_bvalid_0,
  input  logic [1:0]        i_m_cfg_out_m_bresp_0,
  input  logic              i_m_cfg_out_m_rvalid_0,
  input  logic [1:0]        i_m_cfg_out_m_rresp_0,
  input  logic [31:0]       i_m_cfg_out_m_rdata_0
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StResp
  } state_e;

  state_e             r_state, w_state_d;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_awvalid, r_wvalid;
  logic [TMR_W-1:0]   r_timer;
  logic               r_drain;
  logic               r_rsp_valid, r_rsp_error, r_rsp_timeout;
  logic [31:0]        r_rsp_rdata;

  logic               w_req_fire, w_aw_hs, w_w_hs, w_b_hs, w_r_hs, w_done;
  logic               w_busy, w_to_hit, w_rsp_take, w_wr_both;
  logic [TMR_W-1:0]   w_tmr_lim;

  assign w_tmr_lim  = TMR_W'(TIMEOUT_CYCLES);
  assign o_req_ready = (r_state == StIdle) && !r_drain;
  assign w_req_fire = i_req_valid && o_req_ready;
  assign w_aw_hs    = r_awvalid && i_m_cfg_out_m_awready_0;
  assign w_w_hs     = r_wvalid && i_m_cfg_out_m_wready_0;
  assign w_b_hs     = (r_state == StWrResp) && i_m_cfg_out_m_bvalid_0;
  assign w_r_hs     = (r_state == StRdResp) && i_m_cfg_out_m_rvalid_0;
  assign w_done     = w_b_hs || w_r_hs;
  assign w_wr_both  = (!r_awvalid || i_m_cfg_out_m_awready_0) &&
                      (!r_wvalid || i_m_cfg_out_m_wready_0);
  assign w_busy     = (r_state == StWrReq) || (r_state == StWrResp) ||
                      (r_state == StRdReq) || (r_state == StRdResp);
  // A completion in the same cycle as the limit takes priority over the timeout.
  assign w_to_hit   = (TIMEOUT_CYCLES != 0) && w_busy && !r_drain &&
                      (r_timer == w_tmr_lim) && !w_done;
  assign w_rsp_take = r_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_req_fire) w_state_d = i_req_write ? StWrReq : StRdReq;
      StWrReq:  if (w_wr_both) w_state_d = StWrResp;
      StRdReq:  if (i_m_cfg_out_m_arready_0) w_state_d = StRdResp;
      StWrResp, StRdResp: begin
        if (w_done) begin
          if (!r_drain || (r_rsp_valid && !i_rsp_ready)) w_state_d = StResp;
          else                                           w_state_d = StIdle;
        end
      end
      StResp:   if (w_rsp_take) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_timer       <= '0;
      r_drain       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else if (w_req_fire) begin
      r_addr        <= i_req_addr;
      r_wdata       <= i_req_wdata;
      r_wstrb       <= i_req_wstrb;
      r_awvalid     <= i_req_write;
      r_wvalid      <= i_req_write;
      r_timer       <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
      if (w_busy && (r_timer != w_tmr_lim)) r_timer <= r_timer + 1'b1;
      if (w_rsp_take) r_rsp_valid <= 1'b0;
      if (w_done && r_drain) begin
        r_drain <= 1'b0;
      end else if (w_b_hs) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= (i_m_cfg_out_m_bresp_0 != 2'b00);
        r_rsp_rdata <= '0;
      end else if (w_r_hs) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= (i_m_cfg_out_m_rresp_0 != 2'b00);
        r_rsp_rdata <= (i_m_cfg_out_m_rresp_0 == 2'b00) ? i_m_cfg_out_m_rdata_0 : 32'h0;
      end else if (w_to_hit) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_error   <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_rdata   <= '0;
        r_drain       <= 1'b1;
      end
    end
  end

  assign o_rsp_valid            = r_rsp_valid;
  assign o_rsp_rdata            = r_rsp_rdata;
  assign o_rsp_error            = r_rsp_error;
  assign o_rsp_timeout          = r_rsp_timeout;
  assign o_m_cfg_in_m_awvalid_0 = r_awvalid;
  assign o_m_cfg_in_m_awaddr_0  = r_addr;
  assign o_m_cfg_in_m_awprot_0  = PROT;
  assign o_m_cfg_in_m_wvalid_0  = r_wvalid;
  assign o_m_cfg_in_m_wdata_0   = r_wdata;
  assign o_m_cfg_in_m_wstrb_0   = r_wstrb;
  assign o_m_cfg_in_m_bready_0  = (r_state == StWrResp);
  assign o_m_cfg_in_m_arvalid_0 = (r_state == StRdReq);
  assign o_m_cfg_in_m_araddr_0  = r_addr;
  assign o_m_cfg_in_m_arprot_0  = PROT;
  assign o_m_cfg_in_m_rready_0  = (r_state == StRdResp);

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Directed bench for axi_lite_cfg_master: the bench plays the AXI slave cycle by cycle
// and checks every response against hand-computed values.
module tb_axi_lite_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;
  int aw_cnt, w_cnt, b_cnt;
  int cyc;

  axi_lite_cfg_master #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(16),
    .PROT          (3'b000)
  ) u_dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_req_valid            (req_valid),
    .o_req_ready            (req_ready),
    .i_req_write            (req_write),
    .i_req_addr             (req_addr),
    .i_req_wdata            (req_wdata),
    .i_req_wstrb            (req_wstrb),
    .o_rsp_valid            (rsp_valid),
    .i_rsp_ready            (rsp_ready),
    .o_rsp_rdata            (rsp_rdata),
    .o_rsp_error            (rsp_error),
    .o_rsp_timeout          (rsp_timeout),
    .o_m_cfg_in_m_awvalid_0 (awvalid),
    .o_m_cfg_in_m_awaddr_0  (awaddr),
    .o_m_cfg_in_m_awprot_0  (awprot),
    .o_m_cfg_in_m_wvalid_0  (wvalid),
    .o_m_cfg_in_m_wdata_0   (wdata),
    .o_m_cfg_in_m_wstrb_0   (wstrb),
    .o_m_cfg_in_m_bready_0  (bready),
    .o_m_cfg_in_m_arvalid_0 (arvalid),
    .o_m_cfg_in_m_araddr_0  (araddr),
    .o_m_cfg_in_m_arprot_0  (arprot),
    .o_m_cfg_in_m_rready_0  (rready),
    .i_m_cfg_out_m_awready_0(awready),
    .i_m_cfg_out_m_wready_0 (wready),
    .i_m_cfg_out_m_arready_0(arready),
    .i_m_cfg_out_m_bvalid_0 (bvalid),
    .i_m_cfg_out_m_bresp_0  (bresp),
    .i_m_cfg_out_m_rvalid_0 (rvalid),
    .i_m_cfg_out_m_rresp_0  (rresp),
    .i_m_cfg_out_m_rdata_0  (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (bvalid && bready)   b_cnt  <= b_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  // Returns in cycle 1: one cycle after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    tick();
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_wait_bound", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 1; slave_idle();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    #12;
    check("rst_awvalid", {31'b0, awvalid}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    rst_n = 1;
    tick();

    // Zero-wait OKAY write.
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    issue(1'b1, 32'h10, 32'hDEADCAFE, 4'hF);
    check("wr_awvalid_c1", {31'b0, awvalid}, 32'd1);
    check("wr_wvalid_c1", {31'b0, wvalid}, 32'd1);
    check("wr_awaddr", awaddr, 32'h10);
    check("wr_wdata", wdata, 32'hDEADCAFE);
    check("wr_wstrb", {28'b0, wstrb}, 32'hF);
    check("wr_awprot", {29'b0, awprot}, 32'd0);
    tick();
    check("wr_awvalid_c2", {31'b0, awvalid}, 32'd0);
    check("wr_bready_c2", {31'b0, bready}, 32'd1);
    tick();
    check("wr_rsp_valid_c3", {31'b0, rsp_valid}, 32'd1);
    check("wr_rsp_error", {31'b0, rsp_error}, 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check("wr_rsp_valid_c4", {31'b0, rsp_valid}, 32'd0);
    check("wr_req_ready_c4", {31'b0, req_ready}, 32'd1);
    slave_idle();

    // Read with arready delayed 3 cycles.
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("rd_arvalid_hold", {31'b0, arvalid}, 32'd1);
      check("rd_araddr_hold", araddr, 32'h14);
      if (i == 2) arready = 1;
      else        tick();
    end
    rvalid = 1; rdata = 32'h12345678; rresp = 0;
    tick();
    check("rd_arvalid_drop", {31'b0, arvalid}, 32'd0);
    check("rd_rready", {31'b0, rready}, 32'd1);
    tick();
    check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_rsp_error", {31'b0, rsp_error}, 32'd0);
    tick();
    slave_idle();

    // Read with SLVERR.
    arready = 1; rvalid = 1; rresp = 2'b10; rdata = 32'hAAAA5555;
    issue(1'b0, 32'hFFFFFFF0, 32'h0, 4'h0);
    check("slverr_araddr", araddr, 32'hFFFFFFF0);
    wait_rsp(10, cyc);
    check("slverr_latency", cyc, 32'd2);
    check("slverr_error", {31'b0, rsp_error}, 32'd1);
    check("slverr_rdata", rsp_rdata, 32'd0);
    check("slverr_timeout", {31'b0, rsp_timeout}, 32'd0);
    tick();
    slave_idle();

    // Write with DECERR and a partial strobe.
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b11;
    issue(1'b1, 32'h20, 32'h0000BEEF, 4'h3);
    check("decerr_wstrb", {28'b0, wstrb}, 32'h3);
    wait_rsp(10, cyc);
    check("decerr_error", {31'b0, rsp_error}, 32'd1);
    check("decerr_timeout", {31'b0, rsp_timeout}, 32'd0);
    tick();
    slave_idle();

    // Split handshakes (W two cycles before AW), then a stalled response.
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    wready = 1;
    issue(1'b1, 32'h30, 32'h01020304, 4'hF);
    tick();
    check("split_wvalid_c2", {31'b0, wvalid}, 32'd0);
    check("split_awvalid_c2", {31'b0, awvalid}, 32'd1);
    tick();
    check("split_awvalid_c3", {31'b0, awvalid}, 32'd1);
    check("split_awaddr_c3", awaddr, 32'h30);
    awready = 1;
    tick();
    check("split_awvalid_c4", {31'b0, awvalid}, 32'd0);
    check("split_bready_c4", {31'b0, bready}, 32'd1);
    bvalid = 1; rsp_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_error", {31'b0, rsp_error}, 32'd0);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      check("stall_no_axi", {30'b0, awvalid, arvalid}, 32'd0);
      tick();
    end
    rsp_ready = 1;
    tick();
    check("stall_release_rsp", {31'b0, rsp_valid}, 32'd0);
    check("stall_release_ready", {31'b0, req_ready}, 32'd1);
    check("split_aw_count", aw_cnt, 32'd1);
    check("split_w_count", w_cnt, 32'd1);
    check("split_b_count", b_cnt, 32'd1);
    slave_idle();

    // Timeout: B withheld until 40 cycles after accept.
    awready = 1; wready = 1;
    issue(1'b1, 32'h40, 32'h55AA55AA, 4'hF);
    wait_rsp(30, cyc);
    check("to_latency", cyc, 32'd17);
    check("to_error", {31'b0, rsp_error}, 32'd1);
    check("to_timeout", {31'b0, rsp_timeout}, 32'd1);
    check("to_rdata", rsp_rdata, 32'd0);
    check("to_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    for (int i = 19; i < 40; i++) tick();
    check("drain_req_ready", {31'b0, req_ready}, 32'd0);
    check("drain_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("drain_bready", {31'b0, bready}, 32'd1);
    bvalid = 1; bresp = 0;
    tick();
    bvalid = 0;
    check("drain_done_ready", {31'b0, req_ready}, 32'd1);
    check("drain_no_rsp", {31'b0, rsp_valid}, 32'd0);
    arready = 1; rvalid = 1; rresp = 0; rdata = 32'hCAFEF00D;
    issue(1'b0, 32'h44, 32'h0, 4'h0);
    wait_rsp(10, cyc);
    check("post_to_latency", cyc, 32'd2);
    check("post_to_rdata", rsp_rdata, 32'hCAFEF00D);
    check("post_to_error", {31'b0, rsp_error}, 32'd0);
    check("post_to_timeout", {31'b0, rsp_timeout}, 32'd0);
    tick();
    slave_idle();

    // Reset in the middle of a read.
    issue(1'b0, 32'h50, 32'h0, 4'h0);
    check("mid_arvalid", {31'b0, arvalid}, 32'd1);
    tick();
    #2 rst_n = 0;
    #1;
    check("mid_rst_arvalid", {31'b0, arvalid}, 32'd0);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    rst_n = 1;
    tick();
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_rst_arvalid", {31'b0, arvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
